// File: rtl/tx_gearbox_66_64.sv
// Transmit 66:64 gearbox: packs {data, header} blocks LSB-first into a continuous
// 64-bit word stream, stalling the input one cycle whenever the residue reaches 64 bits.
module tx_gearbox_66_64 (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  header_in,
    input  logic [63:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] data_out,
    output logic        out_valid,
    output logic        hdr_err
);

    // Handshake: a block transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state and RST_N, never on in_valid.

    logic [129:0] res_buf;
    logic [6:0]   cnt;

    logic         accept;
    logic [129:0] blk_ext;
    logic [129:0] merged;
    logic [7:0]   total;
    logic         emit;
    logic [6:0]   cnt_nxt;
    logic         bad_hdr;

    assign in_ready = RST_N && (cnt != 7'd64);
    assign accept   = in_valid && in_ready;
    assign bad_hdr  = (header_in[0] == header_in[1]);

    always_comb begin
        blk_ext = {64'b0, data_in, header_in};
        merged  = res_buf;
        total   = {1'b0, cnt};
        if (accept) begin
            merged = res_buf | (blk_ext << cnt);
            total  = {1'b0, cnt} + 8'd66;
        end
        emit    = (total >= 8'd64);
        // At most one word leaves per cycle; a 128-bit merge parks 64 bits for the stall cycle.
        cnt_nxt = emit ? 7'(total - 8'd64) : total[6:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            res_buf   <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (emit) begin
                data_out  <= merged[63:0];
                out_valid <= 1'b1;
                res_buf   <= merged >> 64;
            end else begin
                out_valid <= 1'b0;
                res_buf   <= merged;
            end
            if (accept && bad_hdr)
                hdr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_gearbox_66_64.sv
// Bench for tx_gearbox_66_64: bit-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tx_gearbox_66_64;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  header_in = 2'b00;
    logic [63:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_out;
    logic        out_valid;
    logic        hdr_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    tx_gearbox_66_64 dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .header_in (header_in),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .hdr_err   (hdr_err)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a plain bit FIFO, transmitted order LSB-first
    bit          mq[$];
    logic [63:0] m_data  = '0;
    logic        m_valid = 1'b0;
    logic        m_hdr   = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                mq.delete();
                m_data  = '0;
                m_valid = 1'b0;
                m_hdr   = 1'b0;
            end else begin
                if (in_valid && mq.size() != 64) begin
                    for (int i = 0; i < 2; i++)  mq.push_back(header_in[i]);
                    for (int i = 0; i < 64; i++) mq.push_back(data_in[i]);
                    if (header_in == 2'b00 || header_in == 2'b11) m_hdr = 1'b1;
                end
                if (mq.size() >= 64) begin
                    for (int i = 0; i < 64; i++) m_data[i] = mq.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // scoreboard of emitted words plus run statistics
    logic [63:0] got_q[$];
    int stall_cnt = 0;
    int run_len   = 0;
    int max_run   = 0;
    int ov_cnt    = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("in_ready", 64'(in_ready), 64'(RST_N && mq.size() != 64));
                chk("out_valid", 64'(out_valid), 64'(m_valid));
                chk("data_out", data_out, m_data);
                chk("hdr_err", 64'(hdr_err), 64'(m_hdr));
                if (out_valid) begin
                    got_q.push_back(data_out);
                    ov_cnt++;
                end
                if (RST_N && !in_ready) stall_cnt++;
                run_len = out_valid ? run_len + 1 : 0;
                if (run_len > max_run) max_run = run_len;
            end
        end
    end

    // driver tasks
    task automatic clear_stats();
        got_q.delete();
        stall_cnt = 0;
        run_len   = 0;
        max_run   = 0;
        ov_cnt    = 0;
    endtask

    task automatic do_reset(input int n);
        RST_N    = 1'b0;
        in_valid = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (chk_en) chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        end
        RST_N    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);
        clear_stats();
    endtask

    task automatic send(input logic [1:0] h, input logic [63:0] d);
        bit ok;
        int tries;
        header_in = h;
        data_in   = d;
        in_valid  = 1'b1;
        tries = 0;
        do begin
            ok = in_ready;
            @(posedge CLK);
            #1;
            tries++;
        end while (!ok && tries < 4);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed low for %0d cycles", tries);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    logic [63:0] ref_words[$];

    initial begin
        // reset with in_valid asserted
        do_reset(3);
        chk_en = 1;
        do_reset(3);
        chk("rst_data_out", data_out, 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_hdr_err", 64'(hdr_err), 64'd0);

        // continuous stream of 32 zero-data blocks
        for (int k = 0; k < 32; k++) send(2'b01, 64'h0);
        idle(3);
        chk("stream_words", 64'(got_q.size()), 64'd33);
        for (int k = 0; k < 32 && k < got_q.size(); k++)
            chk($sformatf("stream_word%0d", k), got_q[k], 64'h1 << (2 * k));
        if (got_q.size() > 32) chk("stream_word32", got_q[32], 64'h0);
        chk("stream_stalls", 64'(stall_cnt), 64'd1);
        chk("stream_run", 64'(max_run), 64'd33);
        ref_words = got_q;

        // same stream with a 2-cycle bubble after block 5
        do_reset(2);
        for (int k = 0; k < 5; k++) send(2'b01, 64'h0);
        idle(2);
        for (int k = 5; k < 32; k++) send(2'b01, 64'h0);
        idle(3);
        chk("bubble_words", 64'(got_q.size()), 64'd33);
        chk("bubble_run", 64'(max_run), 64'd28);
        for (int k = 0; k < 33 && k < got_q.size(); k++)
            chk($sformatf("bubble_word%0d", k), got_q[k], ref_words[k]);

        // bad header is flagged but still packed
        do_reset(2);
        send(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("hdr_err_set", 64'(hdr_err), 64'd1);
        for (int k = 0; k < 10; k++) begin
            send($urandom_range(0, 1) ? 2'b01 : 2'b10, {$urandom, $urandom});
            chk("hdr_err_sticky", 64'(hdr_err), 64'd1);
        end
        idle(2);
        if (got_q.size() > 1) begin
            chk("bad_hdr_word0", got_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("bad_hdr_word1_lsbs", 64'(got_q[1][1:0]), 64'd3);
        end else begin
            chk("bad_hdr_words", 64'(got_q.size()), 64'd11);
        end

        // reset mid-stream at residue 30
        do_reset(2);
        for (int k = 0; k < 15; k++) send(2'b01, {$urandom, $urandom});
        do_reset(2);
        send(2'b10, 64'h0);
        idle(2);
        chk("midrst_first_word", got_q.size() > 0 ? got_q[0] : 64'hDEAD, 64'h2);

        // random soak
        do_reset(2);
        for (int k = 0; k < 1000; k++) begin
            send(2'($urandom_range(0, 3)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        chk("soak_residue_bits", 64'(mq.size()), 64'((1000 * 66) % 64));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
